// File: rtl/opb_katadccontroller.sv
// OPB register block for two KATADC boards: reset/DCM control, 3-wire serial config, DCM phase shift.
// Optional DCM phase-shift control is built when KATADC_PHASE_SHIFT_EN is defined.
module opb_katadccontroller #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_FFFF
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:31] OPB_DBus,
  input  logic [0:3]  OPB_BE,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic        adc0_adc3wire_clk,
  output logic        adc0_adc3wire_data,
  output logic        adc0_adc3wire_strobe,
  output logic        adc0_adc_reset,
  output logic        adc0_dcm_reset,
  output logic        adc0_psclk,
  output logic        adc0_psen,
  output logic        adc0_psincdec,
  input  logic        adc0_psdone,
  input  logic        adc0_clk,
  output logic        adc1_adc3wire_clk,
  output logic        adc1_adc3wire_data,
  output logic        adc1_adc3wire_strobe,
  output logic        adc1_adc_reset,
  output logic        adc1_dcm_reset,
  output logic        adc1_psclk,
  output logic        adc1_psen,
  output logic        adc1_psincdec,
  input  logic        adc1_psdone,
  input  logic        adc1_clk
);

  // Numeric views of the big-endian OPB buses (bit 0 = LSB).
  logic [31:0] addr_w, wdata;
  logic [3:0]  be_w;
  logic [31:0] offset;
  logic        in_range, req, wr, rd;
  logic [1:0]  reg_sel;

  assign addr_w   = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign be_w     = OPB_BE;
  assign offset   = addr_w - C_BASEADDR;
  // Addresses below the base wrap to large offsets and fall out of range.
  assign in_range = offset <= (C_HIGHADDR - C_BASEADDR);
  assign req      = OPB_select & in_range & ~Sl_xferAck;
  assign wr       = req & ~OPB_RNW;
  assign rd       = req & OPB_RNW;
  assign reg_sel  = offset[3:2];

  logic        ack_q;
  logic [31:0] dbus_q, dbus_d, rdata;
  logic [3:0]  ctrl_q, ctrl_d;

  // Serial channel state: tick counts 8 OPB cycles per bit over 32 bits.
  logic [1:0]  busy_q, busy_d;
  logic [7:0]  tick_q [2];
  logic [7:0]  tick_d [2];
  logic [31:0] shreg_q [2];
  logic [31:0] shreg_d [2];
  logic [1:0]  cfg_hit, cfg_start;
  logic [31:0] frame;

  logic [1:0]  ps_busy_q, ps_busy_d, psen_q, psen_d, psinc_q, psinc_d;
  logic [1:0]  psdone;

  assign psdone    = {adc1_psdone, adc0_psdone};
  assign frame     = {11'b0, 1'b1, wdata[11:8], wdata[31:16]};
  assign cfg_hit   = {reg_sel == 2'd2, reg_sel == 2'd1};
  assign cfg_start = {2{wr & wdata[0]}} & cfg_hit & ~busy_q;

  always_comb begin
    rdata = 32'h0;
    unique case (reg_sel)
      2'd0: rdata = {26'b0, ctrl_q[3:2], 2'b0, ctrl_q[1:0]};
      2'd1: rdata[0] = busy_q[0];
      2'd2: rdata[0] = busy_q[1];
      2'd3: begin
        rdata[0] = ps_busy_q[0];
        rdata[8] = ps_busy_q[1];
      end
    endcase
  end

  always_comb begin
    dbus_d = rd ? rdata : 32'h0;
    ctrl_d = ctrl_q;
    if (wr && reg_sel == 2'd0 && be_w[0]) begin
      ctrl_d = {wdata[5:4], wdata[1:0]};
    end
  end

  always_comb begin
    busy_d  = busy_q;
    tick_d  = tick_q;
    shreg_d = shreg_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (busy_q[ch]) begin
        tick_d[ch] = tick_q[ch] + 8'd1;
        if (tick_q[ch] == 8'hFF) busy_d[ch] = 1'b0;
        // Shift on the serial clock's falling edge.
        if (tick_q[ch][2:0] == 3'h7) shreg_d[ch] = {shreg_q[ch][30:0], 1'b0};
      end else if (cfg_start[ch]) begin
        busy_d[ch]  = 1'b1;
        tick_d[ch]  = 8'h0;
        shreg_d[ch] = frame;
      end
    end
  end

`ifdef KATADC_PHASE_SHIFT_EN
  always_comb begin
    ps_busy_d = ps_busy_q;
    psen_d    = 2'b00;
    psinc_d   = psinc_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (ps_busy_q[ch]) begin
        if (psdone[ch]) ps_busy_d[ch] = 1'b0;
      end else if (wr && reg_sel == 2'd3 && wdata[8*ch]) begin
        ps_busy_d[ch] = 1'b1;
        psen_d[ch]    = 1'b1;
        psinc_d[ch]   = wdata[8*ch+1];
      end
    end
  end
`else
  always_comb begin
    ps_busy_d = 2'b00;
    psen_d    = 2'b00;
    psinc_d   = 2'b00;
  end
`endif

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q     <= 1'b0;
      dbus_q    <= 32'h0;
      ctrl_q    <= 4'h0;
      busy_q    <= 2'b00;
      tick_q    <= '{default: 8'h0};
      shreg_q   <= '{default: 32'h0};
      ps_busy_q <= 2'b00;
      psen_q    <= 2'b00;
      psinc_q   <= 2'b00;
    end else begin
      ack_q     <= req;
      dbus_q    <= dbus_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      shreg_q   <= shreg_d;
      ps_busy_q <= ps_busy_d;
      psen_q    <= psen_d;
      psinc_q   <= psinc_d;
    end
  end

  assign Sl_xferAck = ack_q;
  assign Sl_DBus    = dbus_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign adc0_adc_reset = ctrl_q[0];
  assign adc1_adc_reset = ctrl_q[1];
  assign adc0_dcm_reset = ctrl_q[2];
  assign adc1_dcm_reset = ctrl_q[3];

  // Serial clock is low for ticks 0-3 and high for 4-7 of each bit.
  assign adc0_adc3wire_strobe = busy_q[0];
  assign adc0_adc3wire_clk    = busy_q[0] & tick_q[0][2];
  assign adc0_adc3wire_data   = busy_q[0] & shreg_q[0][31];
  assign adc1_adc3wire_strobe = busy_q[1];
  assign adc1_adc3wire_clk    = busy_q[1] & tick_q[1][2];
  assign adc1_adc3wire_data   = busy_q[1] & shreg_q[1][31];

  assign adc0_psclk    = OPB_Clk;
  assign adc1_psclk    = OPB_Clk;
  assign adc0_psen     = psen_q[0];
  assign adc1_psen     = psen_q[1];
  assign adc0_psincdec = psinc_q[0];
  assign adc1_psincdec = psinc_q[1];

  logic unused;
  assign unused = ^{offset, wdata, be_w, OPB_seqAddr, adc0_clk, adc1_clk, psdone};

endmodule

// File: tb/tb_opb_katadccontroller.sv
// Randomised bench for opb_katadccontroller: a cycle-level behavioural model checks every output
// on every cycle, and directed transfers pin literal results (serial frames, register reads).
module tb_opb_katadccontroller;

  localparam logic [31:0] Base = 32'h0000_0000;
  localparam logic [31:0] High = 32'h0000_FFFF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus, OPB_DBus;
  logic [0:3]  OPB_BE;
  logic        OPB_RNW, OPB_select, OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic        adc0_adc3wire_clk, adc0_adc3wire_data, adc0_adc3wire_strobe;
  logic        adc1_adc3wire_clk, adc1_adc3wire_data, adc1_adc3wire_strobe;
  logic        adc0_adc_reset, adc0_dcm_reset, adc1_adc_reset, adc1_dcm_reset;
  logic        adc0_psclk, adc0_psen, adc0_psincdec, adc1_psclk, adc1_psen, adc1_psincdec;
  logic [1:0]  psdone;
  logic        adc_clk = 1'b0;
  bit          ps_rand = 1'b0;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_katadccontroller #(.C_BASEADDR(Base), .C_HIGHADDR(High)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_DBus(OPB_DBus),
    .OPB_BE(OPB_BE), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup),
    .adc0_adc3wire_clk(adc0_adc3wire_clk), .adc0_adc3wire_data(adc0_adc3wire_data),
    .adc0_adc3wire_strobe(adc0_adc3wire_strobe), .adc0_adc_reset(adc0_adc_reset),
    .adc0_dcm_reset(adc0_dcm_reset), .adc0_psclk(adc0_psclk), .adc0_psen(adc0_psen),
    .adc0_psincdec(adc0_psincdec), .adc0_psdone(psdone[0]), .adc0_clk(adc_clk),
    .adc1_adc3wire_clk(adc1_adc3wire_clk), .adc1_adc3wire_data(adc1_adc3wire_data),
    .adc1_adc3wire_strobe(adc1_adc3wire_strobe), .adc1_adc_reset(adc1_adc_reset),
    .adc1_dcm_reset(adc1_dcm_reset), .adc1_psclk(adc1_psclk), .adc1_psen(adc1_psen),
    .adc1_psincdec(adc1_psincdec), .adc1_psdone(psdone[1]), .adc1_clk(adc_clk)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          started = 1'b0;
  bit          m_ack;
  logic [31:0] m_rdata, m_ctrl;   // m_ctrl holds the CTRL word as it reads back
  bit          m_act [2];
  int          m_start [2];
  logic [31:0] m_frame [2];
  bit          m_psbusy [2];
  bit          m_psen [2];
  bit          m_psinc [2];

  function automatic logic [31:0] frame_of(input logic [31:0] w);
    return {11'b0, 1'b1, w[11:8], w[31:16]};
  endfunction

  // Frame busy just before edge e: frame launched at edge s lasts 256 cycles.
  function automatic bit busy_before(input int c, input int e);
    return m_act[c] && (e > m_start[c]) && (e - m_start[c] <= 256);
  endfunction

  initial begin
    logic [31:0] off, w, rdv;
    bit          acc;
    bit          b [2];
    bit          psb [2];
    bit          nen [2];
    forever begin
      @(posedge OPB_Clk);
      cyc++;
      started = 1'b1;
      if (OPB_Rst) begin
        m_ack = 0; m_rdata = 0; m_ctrl = 0;
        for (int c = 0; c < 2; c++) begin
          m_act[c] = 0; m_psbusy[c] = 0; m_psen[c] = 0; m_psinc[c] = 0;
        end
      end else begin
        off = OPB_ABus - Base;
        w   = OPB_DBus;
        acc = OPB_select && (off <= High - Base) && !m_ack;
        for (int c = 0; c < 2; c++) begin
          b[c] = busy_before(c, cyc); psb[c] = m_psbusy[c]; nen[c] = 0;
        end
        rdv = 0;
        if (acc && OPB_RNW) begin
          case (off[3:2])
            2'd0: rdv = m_ctrl;
            2'd1: rdv = 32'(b[0]);
            2'd2: rdv = 32'(b[1]);
            default: begin
`ifdef KATADC_PHASE_SHIFT_EN
              rdv = 32'(psb[0]) | (32'(psb[1]) << 8);
`endif
            end
          endcase
        end else if (acc) begin
          case (off[3:2])
            2'd0: if (OPB_BE[3]) m_ctrl = w & 32'h33;
            2'd1, 2'd2: begin
              if (w[0] && !b[off[3:2]-1]) begin
                m_act[off[3:2]-1] = 1; m_start[off[3:2]-1] = cyc;
                m_frame[off[3:2]-1] = frame_of(w);
              end
            end
            default: begin
`ifdef KATADC_PHASE_SHIFT_EN
              for (int c = 0; c < 2; c++) begin
                if (w[8*c] && !psb[c]) begin
                  nen[c] = 1; m_psinc[c] = w[8*c+1];
                end
              end
`endif
            end
          endcase
        end
        for (int c = 0; c < 2; c++) begin
          m_psbusy[c] = psb[c] ? !psdone[c] : nen[c];
          m_psen[c]   = nen[c];
        end
        m_ack = acc; m_rdata = rdv;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    logic [63:0] exp_v, act_v;
    logic [2:0]  ser [2];
    int          k;
    forever begin
      @(negedge OPB_Clk);
      if (started) begin
        for (int c = 0; c < 2; c++) begin
          k = cyc - m_start[c];
          if (m_act[c] && k >= 0 && k <= 255)
            ser[c] = {1'b1, (k % 8) >= 4, m_frame[c][31 - k / 8]};
          else
            ser[c] = 3'b000;
        end
        exp_v = {m_ack, m_rdata, m_ctrl[5], m_ctrl[4], m_ctrl[1], m_ctrl[0], ser[1], ser[0],
                 m_psen[1], m_psinc[1], m_psen[0], m_psinc[0], 4'b0000};
        act_v = {Sl_xferAck, Sl_DBus, adc1_dcm_reset, adc0_dcm_reset, adc1_adc_reset,
                 adc0_adc_reset, adc1_adc3wire_strobe, adc1_adc3wire_clk, adc1_adc3wire_data,
                 adc0_adc3wire_strobe, adc0_adc3wire_clk, adc0_adc3wire_data, adc1_psen,
                 adc1_psincdec, adc0_psen, adc0_psincdec, Sl_errAck, Sl_retry, Sl_toutSup,
                 1'b0};
        check("cycle_outputs", act_v, exp_v);
      end
    end
  end

  // Deserialiser: shifts data on each serial-clock rising edge while strobe is high.
  logic [31:0] cap_word [2];
  int          cap_bits [2];
  int          cap_count [2] = '{0, 0};
  initial begin
    logic [1:0]  s_clk, s_stb, s_dat, p_clk, p_stb;
    logic [31:0] sh [2];
    int          nb [2];
    p_clk = 0; p_stb = 0; sh[0] = 0; sh[1] = 0; nb[0] = 0; nb[1] = 0;
    forever begin
      @(negedge OPB_Clk);
      s_clk = {adc1_adc3wire_clk, adc0_adc3wire_clk};
      s_stb = {adc1_adc3wire_strobe, adc0_adc3wire_strobe};
      s_dat = {adc1_adc3wire_data, adc0_adc3wire_data};
      for (int c = 0; c < 2; c++) begin
        if (s_stb[c] && s_clk[c] && !p_clk[c]) begin
          sh[c] = {sh[c][30:0], s_dat[c]}; nb[c]++;
        end
        if (p_stb[c] && !s_stb[c]) begin
          cap_word[c] = sh[c]; cap_bits[c] = nb[c]; cap_count[c]++;
          sh[c] = 0; nb[c] = 0;
        end
      end
      p_clk = s_clk; p_stb = s_stb;
    end
  end

  initial begin
    forever begin
      @(posedge OPB_Clk);
      #1;
      if (ps_rand) psdone = {($urandom % 4) == 0, ($urandom % 4) == 0};
    end
  end

  // ---------------- stimulus ----------------
  // Called #1 after a rising edge; returns #1 after the ack edge (or after the bound).
  task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wd,
                      input logic [3:0] be, input bit hold, input bit exp_ack,
                      output logic [31:0] rdat);
    bit got = 0;
    OPB_ABus = addr; OPB_DBus = wd; OPB_BE = be; OPB_RNW = rnw; OPB_select = 1'b1;
    rdat = 32'h0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge OPB_Clk);
      #1;
      if (Sl_xferAck) begin
        got = 1; rdat = Sl_DBus;
      end
    end
    if (!hold) OPB_select = 1'b0;
    check("xfer_ack", 64'(got), 64'(exp_ack));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge OPB_Clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] rdat, addr, wd;
    int          n0, n1, sel;
    bit          hold;
    OPB_Rst = 1; OPB_ABus = 0; OPB_DBus = 0; OPB_BE = 0; OPB_RNW = 0; OPB_select = 0;
    OPB_seqAddr = 0; psdone = 0;
    cycles(3);
    OPB_Rst = 0;
    check("reset_outputs", {Sl_xferAck, adc0_adc3wire_strobe, adc1_adc3wire_strobe,
                            adc0_adc_reset, adc1_adc_reset, adc0_psen}, 0);
    xfer(32'h0, 1, 0, 4'hF, 0, 1, rdat);
    check("ctrl_reset_read", rdat, 32'h0);

    xfer(32'h0, 0, 32'h3, 4'b0001, 0, 1, rdat);
    check("ctrl_reset_bits", {adc1_dcm_reset, adc0_dcm_reset, adc1_adc_reset, adc0_adc_reset},
          4'b0011);
    xfer(32'h0, 0, 32'hFFFF_FFFF, 4'b0000, 0, 1, rdat);
    xfer(32'h0, 1, 0, 4'hF, 0, 1, rdat);
    check("ctrl_be_masked", rdat, 32'h3);
    xfer(32'h0, 0, 32'h30, 4'b0001, 0, 1, rdat);
    xfer(32'h0, 1, 0, 4'hF, 0, 1, rdat);
    check("ctrl_dcm_read", rdat, 32'h30);
    xfer(32'h0001_0000, 1, 0, 4'hF, 0, 0, rdat);

    n0 = cap_count[0]; n1 = cap_count[1];
    xfer(32'h4, 0, 32'hDEAD_0901, 4'hF, 1, 1, rdat);
    xfer(32'h8, 0, 32'hBEEF_0801, 4'hF, 0, 1, rdat);
    xfer(32'h4, 1, 0, 4'hF, 0, 1, rdat);
    check("cfg0_busy", rdat, 32'h1);
    xfer(32'h4, 0, 32'h1234_0F01, 4'hF, 0, 1, rdat);
    for (int i = 0; i < 700 && (cap_count[0] == n0 || cap_count[1] == n1); i++) cycles(1);
    check("frame_wait", {cap_count[0] - n0, cap_count[1] - n1}, {32'd1, 32'd1});
    check("frame0_word", cap_word[0], 32'h0019_DEAD);
    check("frame0_bits", cap_bits[0], 32);
    check("frame1_word", cap_word[1], 32'h0018_BEEF);
    check("frame1_bits", cap_bits[1], 32);
    xfer(32'h4, 1, 0, 4'hF, 0, 1, rdat);
    check("cfg0_idle", rdat, 32'h0);

    xfer(32'hC, 0, 32'h3, 4'hF, 0, 1, rdat);
`ifdef KATADC_PHASE_SHIFT_EN
    xfer(32'hC, 1, 0, 4'hF, 0, 1, rdat);
    check("phase_busy", rdat, 32'h1);
    psdone[0] = 1;
    cycles(1);
    psdone[0] = 0;
    xfer(32'hC, 1, 0, 4'hF, 0, 1, rdat);
    check("phase_done", rdat, 32'h0);
`else
    xfer(32'hC, 1, 0, 4'hF, 0, 1, rdat);
    check("phase_disabled_read", rdat, 32'h0);
`endif

    xfer(32'h4, 0, 32'hA5A5_0301, 4'hF, 0, 1, rdat);
    cycles(40);
    OPB_Rst = 1;
    cycles(1);
    check("reset_midframe", {adc0_adc3wire_strobe, adc0_adc3wire_clk, adc0_adc3wire_data}, 0);
    OPB_Rst = 0;
    xfer(32'h0, 1, 0, 4'hF, 0, 1, rdat);
    check("ctrl_after_reset", rdat, 32'h0);

    ps_rand = 1;
    hold = 0;
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 99) == 0 && !hold) begin
        OPB_Rst = 1;
        cycles(1);
        OPB_Rst = 0;
      end
      sel  = $urandom_range(0, 4);
      wd   = $urandom;
      if (sel < 4) addr = ($urandom & 32'h0000_FFF0) | 32'(sel << 2);
      else addr = 32'h0001_0000 + ($urandom & 32'h00FF_FFFF);
      hold = ($urandom_range(0, 3) == 0);
      xfer(addr, $urandom_range(0, 1) == 1, wd, 4'($urandom), hold, sel < 4, rdat);
      if (!hold) cycles($urandom_range(0, 3));
    end
    OPB_select = 0;
    cycles(300);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
